// File: rtl/sync_ctrl_pkg.sv
// Shared state encodings, parameter defaults and helpers for the bit-sync lock controller.
package sync_ctrl_pkg;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } sync_state_t;

  localparam int PERIOD_DEF   = 32;
  localparam int TOL_DEF      = 2;
  localparam int LOCK_CNT_DEF = 4;
  localparam int LOSS_CNT_DEF = 3;
  localparam int I_PHASE_DEF  = 6;
  localparam int Q_PHASE_DEF  = 22;

  localparam int PH_W  = 6;
  localparam int CNT_W = 4;

  // Saturating increment so the edge/miss counters never wrap back to zero.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/sync_edge_win.sv
// Falling-edge detector and timing-window classifier driven by the phase counter.
module sync_edge_win
  import sync_ctrl_pkg::*;
#(
  parameter int PERIOD = PERIOD_DEF,
  parameter int TOL    = TOL_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            din,
  input  logic [PH_W-1:0] ph,
  input  logic            anchor_all,
  output logic            fe,
  output logic            good,
  output logic            miss
);

  localparam logic [PH_W-1:0] LATE_LO  = PH_W'(PERIOD - 1 - TOL);
  localparam logic [PH_W-1:0] EARLY_HI = PH_W'(TOL - 1);
  localparam logic [PH_W-1:0] TOL_PH   = PH_W'(TOL);

  logic din_d;
  logic hit;

  assign fe   = !din && din_d;
  assign good = (ph >= LATE_LO) || (ph <= EARLY_HI);
  assign miss = (ph == TOL_PH) && !hit && !fe;

  // Any edge that re-anchors the phase also counts as this window's hit,
  // otherwise a fresh anchor outside LOCKED would be followed by a spurious miss.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      din_d <= 1'b0;
      hit   <= 1'b0;
    end else begin
      din_d <= din;
      if (fe && (good || anchor_all))
        hit <= 1'b1;
      else if (ph == TOL_PH)
        hit <= 1'b0;
    end
  end

endmodule

// File: rtl/sync_lock_ctrl.sv
// Bit-timing lock controller: acquires a falling-edge carrier, flywheels through
// jitter and dropouts, and emits in-phase / quadrature strobes while locked.
module sync_lock_ctrl
  import sync_ctrl_pkg::*;
#(
  parameter int PERIOD   = PERIOD_DEF,
  parameter int TOL      = TOL_DEF,
  parameter int LOCK_CNT = LOCK_CNT_DEF,
  parameter int LOSS_CNT = LOSS_CNT_DEF,
  parameter int I_PHASE  = I_PHASE_DEF,
  parameter int Q_PHASE  = Q_PHASE_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       din,
  output logic       Isync,
  output logic       Qsync,
  output logic       lock,
  output logic [1:0] state
);

  localparam logic [PH_W-1:0]  PH_LAST = PH_W'(PERIOD - 1);
  localparam logic [PH_W-1:0]  I_PH    = PH_W'(I_PHASE);
  localparam logic [PH_W-1:0]  Q_PH    = PH_W'(Q_PHASE);
  localparam logic [CNT_W-1:0] LOCK_N  = CNT_W'(LOCK_CNT);
  localparam logic [CNT_W-1:0] LOSS_N  = CNT_W'(LOSS_CNT);

  sync_state_t      st;
  logic [PH_W-1:0]  ph;
  logic [CNT_W-1:0] good_cnt;
  logic [CNT_W-1:0] miss_cnt;
  logic [CNT_W-1:0] good_inc;
  logic [CNT_W-1:0] miss_inc;
  logic             fe;
  logic             good;
  logic             miss;
  logic             anchor_all;
  logic             anchor;

  // Outside LOCKED every edge re-anchors; in LOCKED only in-window edges do.
  assign anchor_all = (st != LOCKED);
  assign anchor     = en && fe && (anchor_all || good);
  assign good_inc   = sat_inc(good_cnt);
  assign miss_inc   = sat_inc(miss_cnt);
  assign state      = st;

  sync_edge_win #(
    .PERIOD (PERIOD),
    .TOL    (TOL)
  ) u_edge_win (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .ph         (ph),
    .anchor_all (anchor_all),
    .fe         (fe),
    .good       (good),
    .miss       (miss)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st       <= SEARCH;
      ph       <= '0;
      good_cnt <= '0;
      miss_cnt <= '0;
      Isync    <= 1'b0;
      Qsync    <= 1'b0;
      lock     <= 1'b0;
    end else if (!en) begin
      st       <= SEARCH;
      ph       <= '0;
      good_cnt <= '0;
      miss_cnt <= '0;
      Isync    <= 1'b0;
      Qsync    <= 1'b0;
      lock     <= 1'b0;
    end else begin
      Isync <= (st == LOCKED) && (ph == I_PH);
      Qsync <= (st == LOCKED) && (ph == Q_PH);
      if (anchor || ph == PH_LAST)
        ph <= '0;
      else
        ph <= ph + 1'b1;

      case (st)
        SEARCH: begin
          if (fe) begin
            good_cnt <= '0;
            miss_cnt <= '0;
            st       <= VERIFY;
          end
        end
        VERIFY: begin
          if (fe) begin
            if (good) begin
              good_cnt <= good_inc;
              if (good_inc == LOCK_N) begin
                st       <= LOCKED;
                miss_cnt <= '0;
                lock     <= 1'b1;
              end
            end else begin
              good_cnt <= '0;
            end
          end else if (miss) begin
            st <= SEARCH;
          end
        end
        LOCKED: begin
          if (fe && good) begin
            miss_cnt <= '0;
          end else if (miss) begin
            miss_cnt <= miss_inc;
            if (miss_inc == LOSS_N) begin
              st   <= SEARCH;
              lock <= 1'b0;
            end
          end
        end
        default: begin
          st   <= SEARCH;
          lock <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sync_lock_ctrl.sv
// Directed bench for sync_lock_ctrl: strobe scoreboard plus state/lock spot checks.
module tb_sync_lock_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       din;
  logic       Isync;
  logic       Qsync;
  logic       lock;
  logic [1:0] state;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int last_fe     = 0;
  int a           = 0;
  bit mon_on      = 1'b0;

  typedef struct {
    int         c;
    logic [1:0] iq;
  } exp_t;
  exp_t exp_q[$];

  sync_lock_ctrl dut (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .din   (din),
    .Isync (Isync),
    .Qsync (Qsync),
    .lock  (lock),
    .state (state)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Strobe monitor: expected strobes pop from the scoreboard, all other cycles must be quiet.
  always @(negedge clk) begin
    if (mon_on && !rst) begin
      vectors++;
      if (exp_q.size() > 0 && exp_q[0].c == cyc) begin
        exp_t e;
        e = exp_q.pop_front();
        assert ({Isync, Qsync} === e.iq) else begin
          miscompares++;
          $error("FAIL strobe cyc=%0d observed IQ=%b expected IQ=%b", cyc, {Isync, Qsync}, e.iq);
        end
      end else begin
        assert ({Isync, Qsync} === 2'b00) else begin
          miscompares++;
          $error("FAIL idle_strobe cyc=%0d observed IQ=%b expected IQ=00", cyc, {Isync, Qsync});
        end
      end
    end
  end

  task automatic chk(input string tag, input int got, input int want);
    vectors++;
    assert (got === want) else begin
      miscompares++;
      $error("FAIL %s cyc=%0d observed %0d expected %0d", tag, cyc, got, want);
    end
  endtask

  task automatic step(input logic v);
    din = v;
    @(posedge clk);
    #1;
  endtask

  // Falling edge d cycles after the previous one (din low for a single cycle).
  task automatic fall_after(input int d);
    for (int i = 1; i < d; i++) step(1'b1);
    last_fe = cyc;
    step(1'b0);
  endtask

  task automatic push_strobes(input int anc, input int n);
    for (int m = 0; m < n; m++) begin
      exp_q.push_back('{c: anc + 8 + 32 * m, iq: 2'b10});
      exp_q.push_back('{c: anc + 24 + 32 * m, iq: 2'b01});
    end
  endtask

  initial begin
    rst = 1'b1;
    en  = 1'b1;
    din = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_state", int'(state), 0);
    chk("rst_lock", int'(lock), 0);
    chk("rst_iq", int'({Isync, Qsync}), 0);
    rst = 1'b0;
    step(1'b1);
    step(1'b1);
    chk("idle_state", int'(state), 0);
    mon_on = 1'b1;

    // Acquisition on an ideal 32-cycle carrier
    fall_after(4);
    chk("verify_entry", int'(state), 1);
    for (int i = 1; i <= 4; i++) begin
      fall_after(32);
      if (i < 4) chk("verify_hold", int'(state), 1);
    end
    chk("lock_after_5th", int'(lock), 1);
    chk("locked_state", int'(state), 2);
    push_strobes(last_fe, 1);

    // Jitter at the window limits, then an out-of-window edge at +3
    fall_after(30);
    chk("jit_minus2", int'(lock), 1);
    push_strobes(last_fe, 1);
    fall_after(34);
    chk("jit_plus2", int'(lock), 1);
    push_strobes(last_fe, 2);
    fall_after(35);
    chk("plus3_ignored", int'(lock), 1);
    fall_after(29);
    chk("regrid_lock", int'(lock), 1);
    a = last_fe;
    push_strobes(a, 3);

    // Carrier frozen high: three missed windows drop lock
    while (cyc < a + 99) step(1'b1);
    chk("pre_loss_state", int'(state), 2);
    chk("pre_loss_lock", int'(lock), 1);
    step(1'b1);
    chk("loss_state", int'(state), 0);
    chk("loss_lock", int'(lock), 0);
    repeat (30) step(1'b1);
    chk("queue_drained_1", exp_q.size(), 0);

    // Relock with an edge on the miss cycle and a glitch during VERIFY
    fall_after(5);
    chk("search_to_verify", int'(state), 1);
    fall_after(32);
    chk("verify_good", int'(state), 1);
    fall_after(35);
    chk("tol_edge_verify", int'(state), 1);
    fall_after(32);
    chk("verify_good2", int'(state), 1);
    fall_after(10);
    chk("glitch_verify", int'(state), 1);
    fall_after(22);
    chk("regrid_verify", int'(state), 1);
    for (int i = 1; i <= 3; i++) begin
      fall_after(32);
      chk("post_glitch_nolock", int'(lock), 0);
    end
    fall_after(32);
    chk("post_glitch_lock", int'(lock), 1);
    chk("queue_drained_2", exp_q.size(), 0);
    mon_on = 1'b0;

    // One-cycle enable drop right before an Isync
    a = last_fe;
    while (cyc < a + 7) step(1'b1);
    en = 1'b0;
    step(1'b1);
    chk("en_isync", int'(Isync), 0);
    chk("en_qsync", int'(Qsync), 0);
    chk("en_lock", int'(lock), 0);
    chk("en_state", int'(state), 0);
    en = 1'b1;

    // Relock, then asynchronous reset while Isync is high
    fall_after(5);
    chk("en_relock_verify", int'(state), 1);
    repeat (4) fall_after(32);
    chk("en_relock_lock", int'(lock), 1);
    a = last_fe;
    while (cyc < a + 8) step(1'b1);
    chk("pre_rst_isync", int'(Isync), 1);
    #3 rst = 1'b1;
    #1;
    chk("rst_mid_lock", int'(lock), 0);
    chk("rst_mid_state", int'(state), 0);
    chk("rst_mid_isync", int'(Isync), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // After reset, 1 + LOCK_CNT edges are needed again
    fall_after(5);
    chk("rst_relock_verify", int'(state), 1);
    for (int i = 1; i <= 3; i++) begin
      fall_after(32);
      chk("rst_relock_nolock", int'(lock), 0);
    end
    mon_on = 1'b1;
    fall_after(32);
    chk("rst_relock_lock", int'(lock), 1);
    push_strobes(last_fe, 1);
    repeat (30) step(1'b1);
    chk("queue_drained_3", exp_q.size(), 0);

    mon_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sync_lock_ctrl.md
SYNC_LOCK_CTRL -- requirements
Module: sync_lock_ctrl

Interface
REQ-001 SHALL have parameter PERIOD, default 32: nominal bit-timing period in clk cycles (8..63).
REQ-002 SHALL have parameter TOL, default 2: accepted edge deviation in cycles, either side (1..PERIOD/4).
REQ-003 SHALL have parameter LOCK_CNT, default 4: consecutive good edges required to lock (1..15).
REQ-004 SHALL have parameter LOSS_CNT, default 3: consecutive missed windows that drop lock (1..15).
REQ-005 SHALL have parameters I_PHASE, default 6, and Q_PHASE, default 22: phase-count values that strobe Isync and Qsync (0..PERIOD-1, distinct).
REQ-006 SHALL have port clk, input, 1: the single clock; FPGA system clock.
REQ-007 SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-008 SHALL have port en, input, 1: enable; low forces SEARCH.
REQ-009 SHALL have port din, input, 1: sliced, filtered bit-timing carrier.
REQ-010 SHALL have port Isync, output, 1: in-phase bit strobe, one cycle wide.
REQ-011 SHALL have port Qsync, output, 1: quadrature bit strobe, one cycle wide.
REQ-012 SHALL have port lock, output, 1: high while in LOCKED.
REQ-013 SHALL have port state, output, 2: current state encoding.

Function
REQ-014 SHALL register din into din_d; fe = !din && din_d.
REQ-015 SHALL keep a 6-bit phase counter ph that wraps from PERIOD-1 to 0 and loads 0 on the cycle after any anchoring edge.
REQ-016 SHALL classify fe as good when ph is in [PERIOD-1-TOL, PERIOD-1] or [0, TOL-1]; an edge exactly PERIOD cycles after the previous anchor sees ph = PERIOD-1.
REQ-017 SHALL set hit on a good fe, generate miss when ph == TOL and hit == 0 with no fe that cycle, and clear hit at ph == TOL.
REQ-018 SHALL implement states SEARCH=0, VERIFY=1, LOCKED=2.
REQ-019 In SEARCH, any fe SHALL anchor ph, clear good_cnt and go to VERIFY.
REQ-020 In VERIFY, a good fe SHALL anchor ph and increment good_cnt, going to LOCKED when the incremented value equals LOCK_CNT.
REQ-021 In VERIFY, a bad fe SHALL anchor ph and clear good_cnt, staying in VERIFY.
REQ-022 In VERIFY, a miss SHALL return the state to SEARCH.
REQ-023 In LOCKED, a good fe SHALL anchor ph and clear miss_cnt.
REQ-024 In LOCKED, a bad fe SHALL be ignored, flywheeling ph.
REQ-025 In LOCKED, a miss SHALL increment miss_cnt and go to SEARCH when it reaches LOSS_CNT; ph keeps free-running.
REQ-026 When fe and miss coincide, fe SHALL take priority and miss SHALL be suppressed.
REQ-027 Isync SHALL be registered, high one cycle after a cycle with state == LOCKED and ph == I_PHASE; Qsync the same with Q_PHASE; never both high.
REQ-028 Latency SHALL be: fe at cycle k, ph = 0 at k+1, Isync at k+1+I_PHASE+1.
REQ-029 When en == 0, the next state SHALL be SEARCH, counters clear and Isync/Qsync stay 0; operation resumes the cycle after en returns to 1.
REQ-030 good_cnt and miss_cnt SHALL be 4 bits and saturate, never wrap.

Reset
REQ-031 While rst is high, state SHALL be SEARCH, with ph, good_cnt, miss_cnt, hit, din_d, Isync, Qsync and lock all 0.
REQ-032 A reset mid-lock SHALL discard lock immediately; relock requires 1+LOCK_CNT edges.

Structure
REQ-033 State encodings and parameter defaults SHALL live in the shared package sync_ctrl_pkg.
REQ-034 The edge detector and window classifier SHALL form one sub-module, sync_edge_win, providing fe, good and miss from din and ph.

Verification
REQ-035 Ideal 32-cycle square din, edges at k0+32n -> VERIFY after the 1st fe, lock = 1 the cycle after the 5th fe, Isync at fe+8, Qsync at fe+24.
REQ-036 Lock held, edges jittered by ±2 cycles -> lock stays 1; an edge at +3 is ignored and no Isync phase jump occurs.
REQ-037 Lock held, din frozen high -> miss_cnt 1, 2, 3 at successive windows; SEARCH after the 3rd miss; Isync/Qsync keep flywheeling until then.
REQ-038 VERIFY with a glitch edge 10 cycles after an anchor -> good_cnt cleared; lock needs 4 further good edges.
REQ-039 rst pulse, or en = 0 for one cycle, while LOCKED -> all outputs 0 next cycle, state = SEARCH.
REQ-040 Edge coinciding with the miss cycle (ph == TOL) -> treated as fe, no miss counted.
